// File: rtl/xor_seq_pkg.sv
// xor_seq_pkg: shared state encoding, counter sizing and pulse helper for the XOR pulse sequencer.
package xor_seq_pkg;

    typedef enum logic [3:0] {IDLE, PA, WAB, PB, WCK, PCK, WQ, RSP, GUARD} state_t;

    localparam int SEP_AB_DEF     = 8;
    localparam int SEP_IN_CLK_DEF = 8;
    localparam int SEP_CLK_IN_DEF = 7;
    localparam int Q_TIMEOUT_DEF  = 16;

    function automatic int cnt_width(input int a, input int b, input int c, input int d);
        int m;
        m = a > b ? a : b;
        m = m > c ? m : c;
        m = m > d ? m : d;
        return $clog2(m + 1);
    endfunction

    // A pulse on a toggle-encoded line is one inversion of its level.
    function automatic logic pulse(input logic lvl, input logic fire);
        return lvl ^ fire;
    endfunction

endpackage

// File: rtl/rr_arb2.sv
// rr_arb2: two-way round-robin arbiter; the pointer requester wins ties, pointer flips past the winner.
module rr_arb2 (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       en,
    input  logic [1:0] req,
    output logic [1:0] grant
);

    logic       ptr;
    logic [1:0] pick;

    assign pick  = ptr ? {req[1], ~req[1] & req[0]} : {~req[0] & req[1], req[0]};
    assign grant = en ? pick : 2'b00;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) ptr <= 1'b0;
        else if (|grant) ptr <= ~grant[1];
    end

endmodule

// File: rtl/xor_pulse_sequencer.sv
// xor_pulse_sequencer: shares one clocked RSFQ XOR cell between two requesters,
// spacing a/b/clk pulses and reporting the observed q toggle against a^b.
module xor_pulse_sequencer
    import xor_seq_pkg::*;
#(
    parameter int SEP_AB     = SEP_AB_DEF,
    parameter int SEP_IN_CLK = SEP_IN_CLK_DEF,
    parameter int SEP_CLK_IN = SEP_CLK_IN_DEF,
    parameter int Q_TIMEOUT  = Q_TIMEOUT_DEF
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [1:0] req_valid,
    output logic [1:0] req_ready,
    input  logic [1:0] req_a,
    input  logic [1:0] req_b,
    output logic       rsp_valid,
    input  logic       rsp_ready,
    output logic       rsp_id,
    output logic       rsp_q,
    output logic       rsp_mismatch,
    output logic       cell_a,
    output logic       cell_b,
    output logic       cell_clk,
    input  logic       cell_q,
    output logic       err_spurious,
    output logic       busy
);

    localparam int CW = cnt_width(SEP_AB, SEP_IN_CLK, SEP_CLK_IN, Q_TIMEOUT);

    state_t        state, state_n;
    logic [CW-1:0] cnt, cnt_n, gcnt;
    logic [1:0]    grant;
    logic          gid, a_r, b_r, id_r, q_r, hist, toggle;

    assign toggle       = cell_q != hist;
    assign gid          = grant[1];
    assign req_ready    = grant;
    assign rsp_valid    = state == RSP;
    assign rsp_id       = id_r;
    assign rsp_q        = q_r;
    assign rsp_mismatch = q_r ^ a_r ^ b_r;
    assign busy         = state != IDLE;

    // Grants are gated by reset so req_ready reads 0 while rst_n is low.
    rr_arb2 u_arb (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (rst_n && state == IDLE && gcnt == '0),
        .req   (req_valid),
        .grant (grant)
    );

    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        case (state)
            IDLE:  if (|grant) state_n = req_a[gid] ? PA : req_b[gid] ? PB : PCK;
            PA: begin
                state_n = b_r ? (SEP_AB == 1 ? PB : WAB) : (SEP_IN_CLK == 1 ? PCK : WCK);
                cnt_n   = b_r ? CW'(SEP_AB - 1) : CW'(SEP_IN_CLK - 1);
            end
            WAB: begin
                state_n = cnt == CW'(1) ? PB : WAB;
                cnt_n   = cnt - CW'(1);
            end
            PB: begin
                state_n = SEP_IN_CLK == 1 ? PCK : WCK;
                cnt_n   = CW'(SEP_IN_CLK - 1);
            end
            WCK: begin
                state_n = cnt == CW'(1) ? PCK : WCK;
                cnt_n   = cnt - CW'(1);
            end
            PCK: begin
                state_n = WQ;
                cnt_n   = CW'(Q_TIMEOUT);
            end
            WQ: begin
                state_n = (toggle || cnt == '0) ? RSP : WQ;
                cnt_n   = cnt - CW'(1);
            end
            RSP:   if (rsp_ready) state_n = gcnt == '0 ? IDLE : GUARD;
            GUARD: if (gcnt == '0) state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= IDLE;
            cnt          <= '0;
            gcnt         <= '0;
            hist         <= 1'b0;
            a_r          <= 1'b0;
            b_r          <= 1'b0;
            id_r         <= 1'b0;
            q_r          <= 1'b0;
            cell_a       <= 1'b0;
            cell_b       <= 1'b0;
            cell_clk     <= 1'b0;
            err_spurious <= 1'b0;
        end else begin
            state        <= state_n;
            cnt          <= cnt_n;
            hist         <= cell_q;
            cell_a       <= pulse(cell_a, state == PA);
            cell_b       <= pulse(cell_b, state == PB);
            cell_clk     <= pulse(cell_clk, state == PCK);
            gcnt         <= state == PCK ? CW'(SEP_CLK_IN - 1) : gcnt == '0 ? gcnt : gcnt - CW'(1);
            err_spurious <= err_spurious | (toggle && state != WQ);
            if (state == IDLE && |grant) {a_r, b_r, id_r} <= {req_a[gid], req_b[gid], gid};
            // The last WQ sample decides the result: toggle seen -> 1, timeout -> 0.
            if (state == WQ) q_r <= toggle;
        end
    end

endmodule

// File: tb/tb_xor_pulse_sequencer.sv
// tb_xor_pulse_sequencer: directed bench with a behavioural XOR cell and an expected-response scoreboard.
module tb_xor_pulse_sequencer;

    typedef struct {
        logic id;
        logic q;
        logic mm;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [1:0] req_valid, req_ready, req_a, req_b;
    logic       rsp_valid, rsp_ready, rsp_id, rsp_q, rsp_mismatch;
    logic       cell_a, cell_b, cell_clk, err_spurious, busy;
    logic       cell_q = 1'b0;

    exp_t sb[$];
    int   n_chk = 0, n_fail = 0;
    int   cyc = 0, t0 = 0, ta = -1000, tbt = -1000, tcl = -1000, tr = -1000, last_gap = 0, n_acc = 0;
    int   force_cnt = 0;
    bit   stuck = 0;
    logic eptr = 1'b0;
    logic last_id;

    xor_pulse_sequencer dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_a        (req_a),
        .req_b        (req_b),
        .rsp_valid    (rsp_valid),
        .rsp_ready    (rsp_ready),
        .rsp_id       (rsp_id),
        .rsp_q        (rsp_q),
        .rsp_mismatch (rsp_mismatch),
        .cell_a       (cell_a),
        .cell_b       (cell_b),
        .cell_clk     (cell_clk),
        .cell_q       (cell_q),
        .err_spurious (err_spurious),
        .busy         (busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Accept monitor with its own round-robin model; pushes the expected response.
    always @(posedge clk) begin
        cyc++;
        if (!rst_n) eptr = 1'b0;
        else if (|(req_ready & req_valid)) begin
            logic w, a, b, q;
            exp_t e;
            w = req_valid[eptr] ? eptr : ~eptr;
            chk("rr_grant", {30'd0, req_ready}, w ? 32'd2 : 32'd1);
            a = req_a[w];
            b = req_b[w];
            q = (a ^ b) && !stuck;
            e.id = w;
            e.q  = q;
            e.mm = q ^ a ^ b;
            sb.push_back(e);
            eptr = ~w;
            last_gap = cyc - tcl;
            t0 = cyc;
            n_acc++;
        end
    end

    // Edge-time recorder for cell pulses and response start.
    logic pa = 0, pb = 0, pc = 0, pr = 0;
    always @(negedge clk) begin
        if (rst_n) begin
            if (cell_a !== pa) ta = cyc;
            if (cell_b !== pb) tbt = cyc;
            if (cell_clk !== pc) tcl = cyc;
            if (rsp_valid && !pr) tr = cyc;
        end
        pa = cell_a;
        pb = cell_b;
        pc = cell_clk;
        pr = rsp_valid;
    end

    // Behavioural XOR cell: q toggles 5 ticks after clk when exactly one of a/b was pulsed.
    logic ma = 0, mb = 0, mc = 0, sa = 0, sb_st = 0;
    int   cd = 0, seen = 0;
    always @(negedge clk) begin
        if (!rst_n) begin
            cell_q = 1'b0;
            sa = 0;
            sb_st = 0;
            cd = 0;
            seen = force_cnt;
        end else begin
            if (cd > 0) begin
                cd--;
                if (cd == 0) cell_q = ~cell_q;
            end
            if (force_cnt != seen) begin
                seen = force_cnt;
                cell_q = ~cell_q;
            end
            if (cell_a != ma) sa = ~sa;
            if (cell_b != mb) sb_st = ~sb_st;
            if (cell_clk != mc) begin
                if ((sa ^ sb_st) && !stuck) cd = 5;
                sa = 0;
                sb_st = 0;
            end
        end
        ma = cell_a;
        mb = cell_b;
        mc = cell_clk;
    end

    task automatic issue(input int id, input bit a, input bit b);
        int n = 0;
        req_a[id] = a;
        req_b[id] = b;
        req_valid[id] = 1'b1;
        #1;
        while (!req_ready[id] && n < 300) begin
            @(negedge clk);
            #1;
            n++;
        end
        chk($sformatf("grant_req%0d", id), {31'd0, req_ready[id]}, 32'd1);
        @(negedge clk);
        req_valid[id] = 1'b0;
    endtask

    task automatic get_rsp(input string tag);
        int n = 0;
        exp_t e;
        while (!rsp_valid && n < 300) begin
            @(negedge clk);
            n++;
        end
        chk({tag, "_valid"}, {31'd0, rsp_valid}, 32'd1);
        chk({tag, "_sb"}, {31'd0, sb.size() > 0}, 32'd1);
        if (rsp_valid && sb.size() > 0) begin
            e = sb.pop_front();
            chk({tag, "_id"}, {31'd0, rsp_id}, {31'd0, e.id});
            chk({tag, "_q"}, {31'd0, rsp_q}, {31'd0, e.q});
            chk({tag, "_mm"}, {31'd0, rsp_mismatch}, {31'd0, e.mm});
        end
        last_id = rsp_id;
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
    endtask

    initial begin
        int hold;
        logic prev_id;
        rst_n = 1'b0;
        req_valid = 2'b11;
        req_a = 2'b00;
        req_b = 2'b00;
        rsp_ready = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        chk("rst_cell", {29'd0, cell_a, cell_b, cell_clk}, 32'd0);
        chk("rst_rsp", {28'd0, rsp_valid, rsp_id, rsp_q, rsp_mismatch}, 32'd0);
        chk("rst_misc", {28'd0, req_ready, err_spurious, busy}, 32'd0);
        req_valid = 2'b00;
        @(negedge clk);
        rst_n = 1'b1;

        issue(0, 1, 0);
        get_rsp("t1");
        chk("t1_a_time", ta - t0, 32'd1);
        chk("t1_clk_time", tcl - t0, 32'd9);

        issue(1, 1, 1);
        get_rsp("t2");
        chk("t2_a_time", ta - t0, 32'd1);
        chk("t2_b_time", tbt - t0, 32'd9);
        chk("t2_clk_time", tcl - t0, 32'd17);
        chk("t2_timeout", tr - tcl, 32'd17);

        issue(0, 0, 0);
        get_rsp("t3");
        chk("t3_clk_time", tcl - t0, 32'd1);
        chk("t3_rsp_time", tr - tcl, 32'd17);
        chk("t3_no_data", {31'd0, ta < t0 && tbt < t0}, 32'd1);

        req_a = 2'b00;
        req_b = 2'b11;
        req_valid = 2'b11;
        prev_id = 1'b0;
        for (int i = 0; i < 4; i++) begin
            get_rsp("t4");
            chk("t4_guard_gap", {31'd0, last_gap >= 7}, 32'd1);
            if (i > 0) chk("t4_alternate", {31'd0, last_id != prev_id}, 32'd1);
            prev_id = last_id;
        end
        hold = 0;
        while (!rsp_valid && hold < 300) begin
            @(negedge clk);
            hold++;
        end
        hold = n_acc;
        repeat (30) @(negedge clk);
        chk("t4_hold_no_accept", n_acc, hold);
        chk("t4_hold_ready", {30'd0, req_ready}, 32'd0);
        chk("t4_hold_valid", {31'd0, rsp_valid}, 32'd1);
        req_valid = 2'b00;
        get_rsp("t4h");

        repeat (10) @(negedge clk);
        force_cnt++;
        repeat (3) @(negedge clk);
        chk("t5_err_set", {31'd0, err_spurious}, 32'd1);
        stuck = 1;
        issue(0, 1, 0);
        get_rsp("t5");
        stuck = 0;
        chk("t5_err_sticky", {31'd0, err_spurious}, 32'd1);

        repeat (10) @(negedge clk);
        issue(0, 1, 0);
        repeat (3) @(negedge clk);
        chk("t6_busy_pre", {31'd0, busy}, 32'd1);
        chk("t6_clk_level_pre", {31'd0, cell_clk}, 32'd1);
        rst_n = 1'b0;
        #1;
        chk("t6_rst_cell", {29'd0, cell_a, cell_b, cell_clk}, 32'd0);
        chk("t6_rst_rsp_busy", {29'd0, rsp_valid, busy, err_spurious}, 32'd0);
        sb.delete();
        req_a = 2'b00;
        req_b = 2'b00;
        req_valid = 2'b11;
        repeat (2) @(negedge clk);
        chk("t6_rst_ready", {30'd0, req_ready}, 32'd0);
        rst_n = 1'b1;
        #1;
        chk("t6_first_grant", {30'd0, req_ready}, 32'd1);
        @(negedge clk);
        req_valid = 2'b00;
        get_rsp("t6");

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
